// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// mdio_master : IEEE 802.3 clause-22 MDIO/MDC management master (read/write)
// Rev 1.0     : initial release
// ============================================================================
module mdio_master #(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  localparam int         BIT_W    = (PREAMBLE_LEN > 16) ? $clog2(PREAMBLE_LEN) : 4;
  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    HDR  = 3'd2,
    TA   = 3'd3,
    DATA = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [8:0]       div_cnt, div_nx;
  logic [BIT_W-1:0] bit_cnt, bit_nx, last_bit;
  logic             active_nx, sample, rw_q;
  logic [31:0]      tx_sr;
  logic [15:0]      rx_sr, rx_nx;

  always_comb begin
    last_bit = '0;
    case (state)
      PRE:     last_bit = BIT_W'(PREAMBLE_LEN - 1);
      HDR:     last_bit = BIT_W'(13);
      TA:      last_bit = BIT_W'(1);
      DATA:    last_bit = BIT_W'(15);
      default: last_bit = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = PRE;
          div_nx   = '0;
          bit_nx   = '0;
        end
      end
      PRE, HDR, TA, DATA: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (bit_cnt == last_bit) begin
            bit_nx = '0;
            case (state)
              PRE:     state_nx = HDR;
              HDR:     state_nx = TA;
              TA:      state_nx = DATA;
              default: state_nx = FIN;
            endcase
          end else begin
            bit_nx = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_nx = div_cnt + 9'd1;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
    end
  end

  assign active_nx = (state_nx != IDLE) && (state_nx != FIN);
  // mdio_in is taken in the first cycle of the mdc high phase
  assign sample    = rw_q && ((state == TA) || (state == DATA)) && (div_cnt == DIV_HALF);
  assign rx_nx     = (sample && (state == DATA)) ? {rx_sr[14:0], mdio_in} : rx_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q     <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mdc      <= 1'b0;
      mdio_out <= 1'b1;
      mdio_oe  <= 1'b0;
    end else begin
      busy  <= active_nx;
      done  <= (state_nx == FIN);
      mdc   <= active_nx && (div_nx >= DIV_HALF);
      rx_sr <= rx_nx;
      if ((state == IDLE) && start) begin
        rw_q   <= rw;
        rd_err <= 1'b0;
        // ST, OP, PHYAD, REGAD, TA, DATA; read TA/DATA positions idle high
        tx_sr  <= rw ? {4'b0110, phy_addr, reg_addr, 18'h3FFFF}
                     : {4'b0101, phy_addr, reg_addr, 2'b10, wr_data};
      end
      if (!active_nx) begin
        mdio_out <= 1'b1;
        mdio_oe  <= 1'b0;
      end else if (div_nx == '0) begin
        if (state_nx == PRE) begin
          mdio_out <= 1'b1;
          mdio_oe  <= 1'b1;
        end else begin
          mdio_out <= tx_sr[31];
          tx_sr    <= {tx_sr[30:0], 1'b1};
          mdio_oe  <= (state_nx == HDR) || !rw_q;
        end
      end
      if (sample && (state == TA) && (bit_cnt == BIT_W'(1))) begin
        rd_err <= mdio_in;
      end
      if ((state_nx == FIN) && rw_q) begin
        rd_data <= rx_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mdio_master : directed + randomized bench with a PHY model and frame model
// Rev 1.0        : initial release
// ============================================================================
module tb_mdio_master;

  localparam int PRE_LEN = 32;
  localparam int LIMIT   = 1200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_cmd, sel, rw, mdio_in;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wr_data;

  logic        start_a, start_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        busy_a, done_a, rd_err_a, mdc_a, mdio_out_a, mdio_oe_a;
  logic        busy_b, done_b, rd_err_b, mdc_b, mdio_out_b, mdio_oe_b;

  logic [15:0] rd_data_m;
  logic        busy_m, done_m, rd_err_m, mdc_m, mdio_out_m, mdio_oe_m;

  always #5 clk = ~clk;

  assign start_a    = start_cmd & ~sel;
  assign start_b    = start_cmd & sel;
  assign rd_data_m  = sel ? rd_data_b  : rd_data_a;
  assign busy_m     = sel ? busy_b     : busy_a;
  assign done_m     = sel ? done_b     : done_a;
  assign rd_err_m   = sel ? rd_err_b   : rd_err_a;
  assign mdc_m      = sel ? mdc_b      : mdc_a;
  assign mdio_out_m = sel ? mdio_out_b : mdio_out_a;
  assign mdio_oe_m  = sel ? mdio_oe_b  : mdio_oe_a;

  mdio_master #(.CLK_DIV(4), .PREAMBLE_LEN(PRE_LEN)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rw(rw),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .rd_err(rd_err_a),
    .mdc(mdc_a), .mdio_out(mdio_out_a), .mdio_oe(mdio_oe_a), .mdio_in(mdio_in)
  );

  mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(PRE_LEN)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rw(rw),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .rd_err(rd_err_b),
    .mdc(mdc_b), .mdio_out(mdio_out_b), .mdio_oe(mdio_oe_b), .mdio_in(mdio_in)
  );

  int tests = 0;
  int fails = 0;

  // reference state: expected read result and error flag per instance
  logic [15:0] exp_rd [2];
  logic        exp_err [2];

  // PHY model and serial capture
  logic        resp_on;
  logic [15:0] resp_data;
  logic        mdc_d;
  int          cyc, rises, first_rise, last_rise, done_cnt;
  logic [63:0] cap_out, cap_oe;

  function automatic logic phy_bit(input int idx);
    if (!resp_on)                                  return 1'b1;
    if (idx == PRE_LEN + 15)                       return 1'b0;
    if (idx >= PRE_LEN + 16 && idx < PRE_LEN + 32) return resp_data[PRE_LEN + 31 - idx];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (done_m) done_cnt++;
    if (mdc_m && !mdc_d) begin
      cap_out = {cap_out[62:0], mdio_out_m};
      cap_oe  = {cap_oe[62:0], mdio_oe_m};
      if (rises == 0) first_rise = cyc;
      last_rise = cyc;
      rises++;
    end
    if (!mdc_m && mdc_d) mdio_in = phy_bit(rises);
    mdc_d = mdc_m;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mdc"},     64'(mdc_m),      64'd0);
    check({tag, "_out"},     64'(mdio_out_m), 64'd1);
    check({tag, "_oe"},      64'(mdio_oe_m),  64'd0);
    check({tag, "_busy"},    64'(busy_m),     64'd0);
    check({tag, "_done"},    64'(done_m),     64'd0);
    check({tag, "_rd_err"},  64'(rd_err_m),   64'd0);
    check({tag, "_rd_data"}, 64'(rd_data_m),  64'd0);
  endtask

  task automatic run(input logic s, input logic r, input logic [4:0] pa, input logic [4:0] ra,
                     input logic [15:0] wd, input logic resp, input logic [15:0] rdv,
                     input int dup_at, input int rst_at);
    int          n, d;
    logic [63:0] exp_out, exp_oe, mask;
    d = s ? 1 : 4;
    @(negedge clk);
    sel       = s;
    rises     = 0;
    cap_out   = '0;
    cap_oe    = '0;
    done_cnt  = 0;
    mdc_d     = 1'b0;
    mdio_in   = 1'b1;
    resp_on   = resp;
    resp_data = rdv;
    rw        = r;
    phy_addr  = pa;
    reg_addr  = ra;
    wr_data   = wd;
    start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    n = 1;
    while (!done_m && n < LIMIT) begin
      if (n == dup_at) begin
        start_cmd = 1'b1;
        rw        = ~r;
        phy_addr  = 5'($urandom);
        reg_addr  = 5'($urandom);
        wr_data   = 16'($urandom);
      end
      if (n == dup_at + 1) start_cmd = 1'b0;
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (4) begin
          @(negedge clk);
          check("midrst_no_done", 64'(done_m), 64'd0);
        end
        check("midrst_done_cnt", 64'(done_cnt), 64'd0);
        reset      = 1'b0;
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    check("timeout", 64'(n < LIMIT), 64'd1);
    // n is the done cycle index counting the start cycle as 0
    check("latency", 64'(n + 1), 64'(2 + (PRE_LEN + 32) * 2 * d));
    check("done_count", 64'(done_cnt), 64'd1);
    check("fin_busy", 64'(busy_m), 64'd0);
    check("fin_pins", {61'd0, mdc_m, mdio_out_m, mdio_oe_m}, 64'b010);
    check("bit_count", 64'(rises), 64'(PRE_LEN + 32));
    check("mdc_period", 64'(last_rise - first_rise), 64'(63 * 2 * d));
    exp_out = {32'hFFFF_FFFF, 2'b01, (r ? 2'b10 : 2'b01), pa, ra,
               (r ? 2'b00 : 2'b10), (r ? 16'h0000 : wd)};
    mask    = r ? {{(PRE_LEN + 14){1'b1}}, {18{1'b0}}} : {64{1'b1}};
    exp_oe  = mask;
    check("frame", cap_out & mask, exp_out & mask);
    check("oe_profile", cap_oe, exp_oe);
    if (r) begin
      exp_rd[s]  = resp ? rdv : 16'hFFFF;
      exp_err[s] = !resp;
    end else begin
      exp_err[s] = 1'b0;
    end
    check("rd_data", 64'(rd_data_m), 64'(exp_rd[s]));
    check("rd_err", 64'(rd_err_m), 64'(exp_err[s]));
  endtask

  initial begin
    reset      = 1'b1;
    sel        = 1'b0;
    start_cmd  = 1'b0;
    rw         = 1'b0;
    phy_addr   = '0;
    reg_addr   = '0;
    wr_data    = '0;
    mdio_in    = 1'b1;
    resp_on    = 1'b0;
    resp_data  = '0;
    mdc_d      = 1'b0;
    cyc        = 0;
    rises      = 0;
    first_rise = 0;
    last_rise  = 0;
    done_cnt   = 0;
    cap_out    = '0;
    cap_oe     = '0;
    exp_rd[0]  = '0;
    exp_rd[1]  = '0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;

    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_reset_vals("reset_a");
    sel = 1'b1; #1; check_reset_vals("reset_b");
    reset = 1'b0;
    @(negedge clk);

    run(1'b0, 1'b1, 5'h10, 5'h01, 16'h0000, 1'b1, 16'h786D, -1, -1);
    run(1'b0, 1'b0, 5'h10, 5'h00, 16'h3100, 1'b0, 16'h0000, -1, -1);
    run(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b0, 16'h0, -1, -1);
    run(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), -1, -1);
    run(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), 100, -1);
    run(1'b0, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0, -1, -1);
    run(1'b0, 1'b1, 5'h10, 5'h01, 16'h0, 1'b1, 16'($urandom), -1, 300);
    run(1'b0, 1'b1, 5'h10, 5'h01, 16'h0, 1'b1, 16'($urandom), -1, -1);
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
          1'($urandom), 16'($urandom), -1, -1);
    end

    run(1'b1, 1'b1, 5'h10, 5'h01, 16'h0, 1'b1, 16'h786D, -1, -1);
    run(1'b1, 1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), -1, -1);
    run(1'b1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0, -1, -1);
    run(1'b1, 1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b0, 16'h0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
